// File: rtl/coffee_pkg.sv
// Shared types and arithmetic helpers for the coffee vending controller.
package coffee_pkg;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_CREDIT = 3'd2,
        ST_BREW   = 3'd3,
        ST_REFUND = 3'd4
    } state_t;

    localparam int unsigned STOCK_W = 6;

    function automatic int unsigned price(input int unsigned base, input int unsigned k);
        return base + k;
    endfunction

    // Clamp at max_v; the sum < a test also catches 32-bit wrap-around.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned max_v);
        int unsigned sum;
        sum = a + b;
        if ((sum > max_v) || (sum < a)) begin
            return max_v;
        end else begin
            return sum;
        end
    endfunction

endpackage

// File: rtl/coffee_brew_timer.sv
// Loadable brew down-counter; o_done marks the last enabled cycle of a brew.
module coffee_brew_timer
    import coffee_pkg::*;
#(
    parameter int unsigned BREW_CYCLES = 200
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam int unsigned CNT_W = $clog2(BREW_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(BREW_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // Counter: load on brew entry, count down to zero while brewing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_V;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = i_en && (r_cnt == '0);

endmodule

// File: rtl/coffee_vend.sv
// Multi-product coffee vending controller with coin credit, timed brew and change return.
// Optional cup stock counter enabled by defining COFFEE_CUP_STOCK_EN.
module coffee_vend
    import coffee_pkg::*;
#(
    parameter int unsigned N_PROD      = 4,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned BREW_CYCLES = 200,
    parameter int unsigned PRICE_BASE  = 5
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       on,
    input  logic                       coin_vld,
    input  logic [CREDIT_W-1:0]        coin_val,
    input  logic                       gen,
    input  logic [$clog2(N_PROD)-1:0]  sel,
    input  logic                       cancel,
    output logic                       led,
    output logic                       brew,
    output logic                       change_vld,
    output logic [CREDIT_W-1:0]        change_val,
    output logic [CREDIT_W-1:0]        credit,
    output logic [2:0]                 state_reg
`ifdef COFFEE_CUP_STOCK_EN
    ,
    input  logic                       refill,
    output logic [STOCK_W-1:0]         cups_left,
    output logic                       empty
`endif
);

    localparam int unsigned CMAX = 32'((64'd1 << CREDIT_W) - 64'd1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CREDIT_W-1:0]  r_credit;
    logic [CREDIT_W-1:0]  w_credit_nxt;
    logic                 r_led;
    logic                 r_chg_vld;
    logic [CREDIT_W-1:0]  r_chg_val;
    logic                 w_refund;
    logic [CREDIT_W-1:0]  w_refund_val;
    logic                 w_brew_start;
    logic                 w_brew_done;
    logic                 w_stock_ok;
    logic [CREDIT_W-1:0]  w_coin_add;
    logic [CREDIT_W-1:0]  w_coin_sum;
    logic [CREDIT_W-1:0]  w_brew_credit;
    logic [31:0]          w_price;
    logic                 w_gen_ok;

    assign w_coin_add    = coin_vld ? coin_val : '0;
    assign w_coin_sum    = CREDIT_W'(sat_add(32'(r_credit), 32'(w_coin_add), CMAX));
    assign w_price       = price(PRICE_BASE, 32'(sel));
    // Only read when w_gen_ok guarantees r_credit >= w_price.
    assign w_brew_credit = CREDIT_W'(sat_add(32'(r_credit) - w_price, 32'(w_coin_add), CMAX));
    assign w_gen_ok      = gen && (32'(sel) < N_PROD) && (32'(r_credit) >= w_price) && w_stock_ok;

    coffee_brew_timer #(
        .BREW_CYCLES (BREW_CYCLES)
    ) u_timer (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_load  (w_brew_start),
        .i_en    (r_state == ST_BREW),
        .o_done  (w_brew_done)
    );

    // Next-state and credit update; power loss outranks every panel event.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_refund     = 1'b0;
        w_refund_val = '0;
        w_brew_start = 1'b0;
        if (!on) begin
            if ((r_state == ST_OFF) || (r_state == ST_REFUND) || (w_coin_sum == '0)) begin
                w_state_nxt  = ST_OFF;
                w_credit_nxt = '0;
            end else begin
                w_state_nxt  = ST_REFUND;
                w_refund     = 1'b1;
                w_refund_val = w_coin_sum;
                w_credit_nxt = '0;
            end
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_IDLE: begin
                    if (coin_vld) begin
                        w_state_nxt  = ST_CREDIT;
                        w_credit_nxt = w_coin_sum;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_CREDIT: begin
                    // A coin arriving with cancel is returned with the rest of the credit.
                    if (cancel) begin
                        w_state_nxt  = ST_REFUND;
                        w_refund     = 1'b1;
                        w_refund_val = w_coin_sum;
                        w_credit_nxt = '0;
                    end else if (w_gen_ok) begin
                        w_state_nxt  = ST_BREW;
                        w_brew_start = 1'b1;
                        w_credit_nxt = w_brew_credit;
                    end else begin
                        w_credit_nxt = w_coin_sum;
                    end
                end
                ST_BREW: begin
                    if (w_brew_done && (w_coin_sum != '0)) begin
                        w_state_nxt  = ST_REFUND;
                        w_refund     = 1'b1;
                        w_refund_val = w_coin_sum;
                        w_credit_nxt = '0;
                    end else if (w_brew_done) begin
                        w_state_nxt  = ST_IDLE;
                        w_credit_nxt = '0;
                    end else begin
                        w_credit_nxt = w_coin_sum;
                    end
                end
                ST_REFUND: begin
                    w_state_nxt  = ST_IDLE;
                    w_credit_nxt = '0;
                end
                default: begin
                    w_state_nxt  = ST_OFF;
                    w_credit_nxt = '0;
                end
            endcase
        end
    end

    // State, credit and registered output drivers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_OFF;
            r_credit  <= '0;
            r_led     <= 1'b0;
            r_chg_vld <= 1'b0;
            r_chg_val <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_credit  <= w_credit_nxt;
            r_led     <= (w_state_nxt == ST_BREW);
            r_chg_vld <= w_refund;
            r_chg_val <= w_refund_val;
        end
    end

`ifdef COFFEE_CUP_STOCK_EN
    logic [STOCK_W-1:0] r_cups;
    logic [STOCK_W-1:0] w_cups_nxt;
    logic               r_empty;

    assign w_stock_ok = (r_cups != '0);
    assign w_cups_nxt = refill       ? {STOCK_W{1'b1}} :
                        w_brew_start ? (r_cups - STOCK_W'(1)) : r_cups;

    // Cup stock counter and its empty flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cups  <= '0;
            r_empty <= 1'b1;
        end else begin
            r_cups  <= w_cups_nxt;
            r_empty <= (w_cups_nxt == '0);
        end
    end

    assign cups_left = r_cups;
    assign empty     = r_empty;
`else
    assign w_stock_ok = 1'b1;
`endif

    assign led        = r_led;
    assign brew       = r_led;
    assign change_vld = r_chg_vld;
    assign change_val = r_chg_val;
    assign credit     = r_credit;
    assign state_reg  = r_state;

endmodule

// File: tb/tb_coffee_vend.sv
// Self-checking bench for coffee_vend: directed table, corner sequences, random vs. model.
module tb_coffee_vend;

    localparam int TB_BC = 12;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       on = 1'b0;
    logic       coin_vld = 1'b0;
    logic [7:0] coin_val = 8'd0;
    logic       gen = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;
    logic       led, brew, change_vld;
    logic [7:0] change_val, credit;
    logic [2:0] state_reg;
`ifdef COFFEE_CUP_STOCK_EN
    logic       refill = 1'b0;
    logic [5:0] cups_left;
    logic       empty;
`endif

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state (spec-level quantities).
    int m_st, m_cr, m_left, m_cv, m_cval, m_cups;

    always #5 clock = ~clock;

    coffee_vend #(
        .N_PROD(4), .CREDIT_W(8), .BREW_CYCLES(TB_BC), .PRICE_BASE(5)
    ) dut (
        .clock(clock), .reset(reset), .on(on), .coin_vld(coin_vld), .coin_val(coin_val),
        .gen(gen), .sel(sel), .cancel(cancel), .led(led), .brew(brew),
        .change_vld(change_vld), .change_val(change_val), .credit(credit),
        .state_reg(state_reg)
`ifdef COFFEE_CUP_STOCK_EN
        , .refill(refill), .cups_left(cups_left), .empty(empty)
`endif
    );

    typedef struct {
        logic       on, cv;
        logic [7:0] cval;
        logic       g;
        logic [1:0] s;
        logic       c;
        int         st, cr, ld, chv, chval;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int st, input int cr, input int ld,
                            input int chv, input int chval);
        chk({tag, "_state"}, int'(state_reg), st);
        chk({tag, "_credit"}, int'(credit), cr);
        chk({tag, "_led"}, int'(led), ld);
        chk({tag, "_brew"}, int'(brew), ld);
        chk({tag, "_chg_vld"}, int'(change_vld), chv);
        chk({tag, "_chg_val"}, int'(change_val), chval);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        coin_vld = 1'b0; coin_val = 8'd0; gen = 1'b0; sel = 2'd0; cancel = 1'b0;
`ifdef COFFEE_CUP_STOCK_EN
        refill = 1'b0;
`endif
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic m_refund(input int v);
        m_cv = 1; m_cval = v; m_cr = 0; m_st = 4;
    endtask

    // One clock of the specification's rules applied to the current inputs.
    task automatic model_step();
        int coin, tot, pr, stock_ok, start, rf;
        coin  = coin_vld ? int'(coin_val) : 0;
        tot   = min255(m_cr + coin);
        pr    = 5 + int'(sel);
        m_cv  = 0; m_cval = 0; start = 0; rf = 0;
`ifdef COFFEE_CUP_STOCK_EN
        stock_ok = (m_cups > 0) ? 1 : 0;
        rf = int'(refill);
`else
        stock_ok = 1;
`endif
        if (m_st == 0) begin
            m_st = on ? 1 : 0;
        end else if (m_st == 4) begin
            m_st = on ? 1 : 0; m_cr = 0;
        end else if (!on) begin
            if (tot > 0) m_refund(tot);
            else begin m_st = 0; m_cr = 0; end
        end else if (m_st == 1) begin
            if (coin_vld) begin m_cr = coin; m_st = 2; end
        end else if (m_st == 2) begin
            if (cancel) m_refund(tot);
            else if (gen && int'(sel) < 4 && m_cr >= pr && stock_ok == 1) begin
                m_cr = min255(m_cr - pr + coin); m_st = 3; m_left = TB_BC; start = 1;
            end else m_cr = tot;
        end else begin
            m_cr = tot; m_left--;
            if (m_left == 0) begin
                if (m_cr > 0) m_refund(m_cr);
                else m_st = 1;
            end
        end
        if (rf == 1) m_cups = 63;
        else if (start == 1) m_cups--;
    endtask

    initial begin
        // Reset state while reset is held low.
        on = 1'b0;
        do_reset();
        chk_outs("reset", 0, 0, 0, 0, 0);
`ifdef COFFEE_CUP_STOCK_EN
        chk("reset_cups", int'(cups_left), 0);
        chk("reset_empty", int'(empty), 1);
`endif
        cyc();
        chk("off_hold_state", int'(state_reg), 0);

        //         on    cv    cval     g     s     c     st cr ld chv chval
        tbl[0]  = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 1, 0,   0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 8'd5,   1'b0, 2'd0, 1'b0, 2, 5,   0, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 8'd0,   1'b1, 2'd3, 1'b0, 2, 5,   0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b1, 4, 0,   0, 1, 5};
        tbl[4]  = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 1, 0,   0, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 8'd250, 1'b0, 2'd0, 1'b0, 2, 250, 0, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 8'd10,  1'b0, 2'd0, 1'b0, 2, 255, 0, 0, 0};
        tbl[7]  = '{1'b1, 1'b0, 8'd0,   1'b1, 2'd0, 1'b1, 4, 0,   0, 1, 255};
        tbl[8]  = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 1, 0,   0, 0, 0};
        tbl[9]  = '{1'b1, 1'b0, 8'd0,   1'b1, 2'd0, 1'b0, 1, 0,   0, 0, 0};
        tbl[10] = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b1, 1, 0,   0, 0, 0};
        tbl[11] = '{1'b1, 1'b1, 8'd9,   1'b0, 2'd0, 1'b0, 2, 9,   0, 0, 0};
        tbl[12] = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b1, 4, 0,   0, 1, 9};
        tbl[13] = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 1, 0,   0, 0, 0};
        tbl[14] = '{1'b1, 1'b1, 8'd3,   1'b0, 2'd0, 1'b0, 2, 3,   0, 0, 0};
        tbl[15] = '{1'b0, 1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 4, 0,   0, 1, 3};
        tbl[16] = '{1'b0, 1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 0, 0,   0, 0, 0};
        tbl[17] = '{1'b1, 1'b0, 8'd0,   1'b0, 2'd0, 1'b0, 1, 0,   0, 0, 0};

        for (int i = 0; i < 18; i++) begin
            on = tbl[i].on; coin_vld = tbl[i].cv; coin_val = tbl[i].cval;
            gen = tbl[i].g; sel = tbl[i].s; cancel = tbl[i].c;
            cyc();
            clr_in();
            chk_outs($sformatf("tbl%0d", i), tbl[i].st, tbl[i].cr, tbl[i].ld,
                     tbl[i].chv, tbl[i].chval);
        end

`ifdef COFFEE_CUP_STOCK_EN
        refill = 1'b1; cyc(); clr_in();
`endif
        // Full brew: 5+3 credit, product 2 costs 7, change of 1 afterwards.
        coin_vld = 1'b1; coin_val = 8'd5; cyc();
        coin_val = 8'd3; cyc(); clr_in();
        chk("brew_credit8", int'(credit), 8);
        gen = 1'b1; sel = 2'd2; cyc(); clr_in();
        chk_outs("brew_start", 3, 1, 1, 0, 0);
        begin
            int n;
            n = 1;
            for (int k = 0; k < 3 * TB_BC; k++) begin
                cyc();
                if (!brew) break;
                n++;
            end
            chk("brew_len", n, TB_BC);
        end
        chk_outs("brew_refund", 4, 0, 0, 1, 1);
        cyc();
        chk_outs("brew_idle", 1, 0, 0, 0, 0);

        // Power off mid-brew with credit 4 refunds, then OFF.
        coin_vld = 1'b1; coin_val = 8'd9; cyc(); clr_in();
        gen = 1'b1; sel = 2'd0; cyc(); clr_in();
        chk_outs("pwr_brew", 3, 4, 1, 0, 0);
        repeat (3) cyc();
        on = 1'b0; cyc();
        chk_outs("pwr_refund", 4, 0, 0, 1, 4);
        cyc();
        chk_outs("pwr_off", 0, 0, 0, 0, 0);
        on = 1'b1; cyc();
        chk("pwr_on_idle", int'(state_reg), 1);

        // Asynchronous reset mid-brew clears outputs between clock edges.
        coin_vld = 1'b1; coin_val = 8'd6; cyc(); clr_in();
        gen = 1'b1; sel = 2'd0; cyc(); clr_in();
        chk("arst_pre_brew", int'(brew), 1);
        cyc();
        #2;
        reset = 1'b0;
        #1;
        chk_outs("arst", 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;

`ifdef COFFEE_CUP_STOCK_EN
        // Cup stock: empty after reset blocks gen until a refill.
        do_reset();
        on = 1'b1; cyc();
        coin_vld = 1'b1; coin_val = 8'd10; cyc(); clr_in();
        gen = 1'b1; sel = 2'd0; cyc(); clr_in();
        chk("stk_blocked_state", int'(state_reg), 2);
        chk("stk_blocked_credit", int'(credit), 10);
        chk("stk_empty", int'(empty), 1);
        refill = 1'b1; cyc(); clr_in();
        chk("stk_refill", int'(cups_left), 63);
        chk("stk_not_empty", int'(empty), 0);
        gen = 1'b1; sel = 2'd0; cyc(); clr_in();
        chk("stk_brew_state", int'(state_reg), 3);
        chk("stk_cups62", int'(cups_left), 62);
`endif

        // Random stimulus against the reference model.
        on = 1'b0;
        do_reset();
        m_st = 0; m_cr = 0; m_left = 0; m_cv = 0; m_cval = 0; m_cups = 0;
        for (int t = 0; t < 4000; t++) begin
            on       = ($urandom_range(0, 39) != 0);
            coin_vld = ($urandom_range(0, 3) == 0);
            coin_val = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(150, 255))
                                                   : 8'($urandom_range(0, 12));
            gen      = ($urandom_range(0, 2) == 0);
            sel      = 2'($urandom_range(0, 3));
            cancel   = ($urandom_range(0, 11) == 0);
`ifdef COFFEE_CUP_STOCK_EN
            refill   = ($urandom_range(0, 29) == 0);
`endif
            model_step();
            cyc();
            chk_outs("rnd", m_st, m_cr, (m_st == 3) ? 1 : 0, m_cv, m_cval);
`ifdef COFFEE_CUP_STOCK_EN
            chk("rnd_cups", int'(cups_left), m_cups);
            chk("rnd_empty", int'(empty), (m_cups == 0) ? 1 : 0);
`endif
        end
        clr_in();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/coffee_vend.md
Name: coffee_vend

Overview:
- Parametrised successor to the single-product coffee FSM.
- Adds coin credit accumulation, N selectable products with per-product price, a timed brew phase driven by a cycle counter, and a change return.
- Sits between front-panel inputs (power, coin, select, cancel) and the brew/LED drivers.
- Exposes encoded state for debug and LEDs.

Parameters:
- N_PROD, 4, number of selectable products (2..8).
- CREDIT_W, 8, width of credit and price values (currency units).
- BREW_CYCLES, 200, clock cycles the brew output stays high (>=2).
- PRICE_BASE, 5, price of product 0; product k costs PRICE_BASE + k.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- on  in  1  power switch level; 0 forces OFF.
- coin_vld  in  1  one-cycle pulse, coin accepted.
- coin_val  in  CREDIT_W  coin value, sampled when coin_vld=1.
- gen  in  1  one-cycle pulse, brew request for sel.
- sel  in  $clog2(N_PROD)  product index, sampled with gen.
- cancel  in  1  one-cycle pulse, refund credit.
- led  out  1  brewing indicator (high in BREW).
- brew  out  1  heater/pump enable (same as led).
- change_vld  out  1  one-cycle pulse with change_val.
- change_val  out  CREDIT_W  amount returned.
- credit  out  CREDIT_W  current credit.
- state_reg  out  3  encoded FSM state.

Behaviour:
- Reset (reset=0, async): state=OFF; credit=0; led=brew=0; change_vld=0; change_val=0; brew counter=0.
- States (3-bit): OFF=0, IDLE=1, CREDIT=2, BREW=3, REFUND=4.
- OFF -> IDLE when on=1. Any state -> OFF on the next edge when on=0. On that transition, nonzero credit is refunded first: one REFUND cycle, then OFF.
- IDLE: coin_vld adds coin_val to credit and moves to CREDIT. gen with credit 0 is ignored.
- CREDIT:
  - coin_vld adds to credit, saturating at 2^CREDIT_W-1. Excess coin value is lost and flagged by no output.
  - gen with sel<N_PROD and credit>=price(sel): credit -= price and go to BREW. The counter loads BREW_CYCLES-1.
  - gen with insufficient credit or sel>=N_PROD is ignored.
  - cancel -> REFUND.
- Simultaneous events in one cycle, priority: on=0 > cancel > gen > coin. A coin arriving in the same cycle as a winning gen is still added, after the price subtraction.
- BREW:
  - led=brew=1 for exactly BREW_CYCLES cycles. The counter decrements each cycle; at 0 the FSM goes to REFUND if credit>0, else IDLE.
  - Coins are accepted and accumulated during BREW. gen and cancel are ignored.
- REFUND: lasts one cycle. change_vld=1 and change_val=credit (registered). Credit clears to 0 and the FSM goes to IDLE, or to OFF if on=0.
- All outputs are registered. state_reg reflects the current state. Latency from gen to brew=1 is one cycle.
- Reset asserted mid-BREW: brew drops immediately (async) and credit is lost.

Optional Feature:
- COFFEE_CUP_STOCK_EN.
  - Defined: adds a STOCK_W=6 cup counter, reset to 0, and ports refill (in, 1-cycle pulse, loads 63) and cups_left (out, 6). Each BREW entry decrements the counter. gen is ignored while cups_left=0, and an extra output empty=1 is driven.
  - Undefined: unlimited cups; no extra ports.

Decomposition:
- Shared package coffee_pkg: state enum/localparams (OFF..REFUND), price function price(k)=PRICE_BASE+k, and a saturating-add function.
- One natural sub-module, coffee_brew_timer: loadable down-counter with a done pulse, parameterised by BREW_CYCLES.

Test Plan:
1. Reset low 2 cycles, on=1 -> state_reg 0 then 1; credit=0, led=0, change_vld=0.
2. Coins 5+3, gen sel=2 (price 7) -> BREW for exactly BREW_CYCLES cycles with led=1. Then REFUND with change_val=1 for one cycle, then IDLE.
3. Credit 5, gen sel=3 (price 8) -> ignored, state stays CREDIT; cancel -> change_vld=1, change_val=5, credit=0.
4. Same cycle cancel+gen with sufficient credit -> REFUND wins, no BREW. Coins 250+10 with CREDIT_W=8 -> credit saturates at 255.
5. on=0 mid-BREW with credit 4 -> brew drops, REFUND change_val=4, then OFF. Async reset mid-BREW -> outputs clear without waiting for a clock edge.
6. With COFFEE_CUP_STOCK_EN defined, no refill: credit 10, gen sel=0 -> ignored, empty=1. After refill pulse, gen -> BREW, cups_left=62.
